piso_serializer: RTL and testbench
==================================

PISO_SERIALIZER -- requirements
Module: piso_serializer

Interface
REQ-001 Parameter: HOLD_CYCLES, default 1, clock cycles each bit is held on data_out; legal range 1..255.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 in_valid  input  1  upstream offers data_in this cycle.
REQ-005 data_in  input  8  parallel word to serialize.
REQ-006 in_ready  output  1  block accepts data_in this cycle.
REQ-007 select  output  3  current bit index; drives the select input of the downstream 8:1 mux.
REQ-008 data_out  output  1  serial bit, equal to the held word at bit position select.
REQ-009 out_valid  output  1  data_out/select are meaningful.
REQ-010 last_bit  output  1  final cycle of the final bit of the current word.

Function
REQ-011 States: IDLE and SHIFT only.
REQ-012 IDLE: in_ready=1, out_valid=0, select=start index, data_out=0.
REQ-013 Handshake: transfer when in_valid && in_ready at a rising edge; word registered internally; state -> SHIFT.
REQ-014 data_in ignored when no transfer occurs; held word unaffected by data_in changes during SHIFT.
REQ-015 SHIFT: in_ready=0, out_valid=1; first bit is presented in the cycle after the transfer (latency 1).
REQ-016 Each index is held exactly HOLD_CYCLES cycles; an internal hold counter counts 0..HOLD_CYCLES-1, then select steps.
REQ-017 Word duration is exactly 8*HOLD_CYCLES cycles in SHIFT.
REQ-018 last_bit=1 only in the last SHIFT cycle (final index, hold counter at HOLD_CYCLES-1).
REQ-019 After the last_bit cycle: state -> IDLE, select -> start index, in_ready=1 in the following cycle; minimum word-to-word period is 8*HOLD_CYCLES+1 cycles.
REQ-020 Select wraps only via the return to IDLE; it never steps past the end index.
REQ-021 in_valid held high continuously -> back-to-back words with exactly one IDLE cycle between them.
REQ-022 All outputs are registered, except data_out, which is a combinational select from the held word and the select register.

Reset
REQ-023 rst_n low asynchronously forces IDLE, select=start index, hold counter=0, held word=0, out_valid=0, last_bit=0, data_out=0; in_ready=1.
REQ-024 Reset in SHIFT aborts the word; the remaining bits are never emitted, and the next accepted word starts from the start index.
REQ-025 First transfer is possible at the first rising edge after rst_n deasserts.

Configuration
REQ-026 Macro PISO_MSB_FIRST_EN: defined -> start index 7, select decrements, end index 0.
REQ-027 Macro undefined -> start index 0, select increments, end index 7 (LSB first).

Structure
REQ-028 Package piso_pkg holds WORD_W=8, SEL_W=3, the state enum (IDLE, SHIFT) and the start/end index constants selected by the macro.
REQ-029 Sub-module bit_hold_timer (parameter HOLD_CYCLES; inputs clk, rst_n, run; output tick) generates the per-bit step pulse.

Verification
REQ-030 LSB mode, HOLD_CYCLES=1, data_in=8'b10101010 accepted at T -> T+1..T+8: select 0..7, data_out 0,1,0,1,0,1,0,1; last_bit at T+8; in_ready at T+9.
REQ-031 PISO_MSB_FIRST_EN, same word -> select 7..0, data_out 1,0,1,0,1,0,1,0.
REQ-032 HOLD_CYCLES=3, data_in=8'hF0 -> each select value held 3 cycles; out_valid high 24 cycles; last_bit a single 1-cycle pulse.
REQ-033 in_valid held high with 8'h01 then 8'h80 -> exactly one in_ready cycle between words; second word starts 9 cycles after the first transfer.
REQ-034 rst_n low at the 4th bit of 8'hFF -> immediate out_valid=0, select=0; next word 8'h0F serializes completely from index 0.
REQ-035 data_in toggled during SHIFT -> serial output unchanged from the captured word.

Source files
------------

// File: rtl/piso_pkg.sv
// Shared definitions for the parallel-in serial-out serializer.
// Macro PISO_MSB_FIRST_EN: when defined the word is sent MSB first
// (select counts 7 down to 0); otherwise LSB first (0 up to 7).
package piso_pkg;

  localparam int WORD_W = 8;
  localparam int SEL_W  = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

`ifdef PISO_MSB_FIRST_EN
  localparam logic [SEL_W-1:0] START_IDX = 3'd7;
  localparam logic [SEL_W-1:0] END_IDX   = 3'd0;
  localparam bit               SEL_DOWN  = 1'b1;
`else
  localparam logic [SEL_W-1:0] START_IDX = 3'd0;
  localparam logic [SEL_W-1:0] END_IDX   = 3'd7;
  localparam bit               SEL_DOWN  = 1'b0;
`endif

  // Bit index that follows sel in transmission order.
  function automatic logic [SEL_W-1:0] nextSel(input logic [SEL_W-1:0] sel);
    if (SEL_DOWN) begin
      return sel - SEL_W'(1);
    end
    return sel + SEL_W'(1);
  endfunction

endpackage

// File: rtl/piso_serializer_bit_hold_timer.sv
// Per-bit hold timer for piso_serializer.
// 'run' states whether the serializer will be shifting in the coming cycle.
// 'tick' is a look-ahead: it is high when the coming cycle is the final hold
// cycle of the current bit, so the parent can register its step and last_bit.
module bit_hold_timer #(
  parameter int HOLD_CYCLES = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic tick
);

  localparam logic [7:0] LAST = 8'(HOLD_CYCLES - 1);

  logic [7:0] count_q;
  logic [7:0] count_d;
  logic       running_q;

  // The count restarts at zero on the first shifting cycle and wraps after LAST.
  always_comb begin
    count_d = 8'd0;
    if (run && running_q) begin
      count_d = (count_q == LAST) ? 8'd0 : count_q + 8'd1;
    end
  end

  assign tick = run && (count_d == LAST);

  // Hold count and a record of whether the previous cycle was shifting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q   <= 8'd0;
      running_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      running_q <= run;
    end
  end

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in serial-out serializer: accepts an 8-bit word on a valid/ready
// handshake and presents it one bit per HOLD_CYCLES cycles, with select
// driving a downstream 8:1 mux. Bit order is chosen by PISO_MSB_FIRST_EN.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int HOLD_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [WORD_W-1:0] data_in,
  output logic              in_ready,
  output logic [SEL_W-1:0]  select,
  output logic              data_out,
  output logic              out_valid,
  output logic              last_bit
);

  state_e             state_q;
  logic [SEL_W-1:0]   sel_q;
  logic [WORD_W-1:0]  word_q;
  logic               outValid_q;
  logic               inReady_q;
  logic               lastBit_q;
  logic               step_q;
  logic               tick;
  logic               finalStep;
  logic               runNext;

  assign finalStep = step_q && (sel_q == END_IDX);
  assign runNext   = (state_q == IDLE) ? in_valid : !finalStep;

  bit_hold_timer #(
    .HOLD_CYCLES(HOLD_CYCLES)
  ) u_timer (
    .clk  (clk),
    .rst_n(rst_n),
    .run  (runNext),
    .tick (tick)
  );

  // Handshake, bit stepping and registered status outputs in one state machine.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      sel_q      <= START_IDX;
      word_q     <= '0;
      outValid_q <= 1'b0;
      inReady_q  <= 1'b1;
      lastBit_q  <= 1'b0;
      step_q     <= 1'b0;
    end else begin
      step_q <= tick;
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            state_q    <= SHIFT;
            word_q     <= data_in;
            sel_q      <= START_IDX;
            outValid_q <= 1'b1;
            inReady_q  <= 1'b0;
            lastBit_q  <= 1'b0;
          end
        end
        SHIFT: begin
          if (finalStep) begin
            state_q    <= IDLE;
            sel_q      <= START_IDX;
            outValid_q <= 1'b0;
            inReady_q  <= 1'b1;
            lastBit_q  <= 1'b0;
          end else if (step_q) begin
            sel_q     <= nextSel(sel_q);
            lastBit_q <= tick && (nextSel(sel_q) == END_IDX);
          end else begin
            lastBit_q <= tick && (sel_q == END_IDX);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = inReady_q;
  assign select    = sel_q;
  assign out_valid = outValid_q;
  assign last_bit  = lastBit_q;
  assign data_out  = outValid_q & word_q[sel_q];

endmodule

// File: tb/tb_piso_serializer.sv
// Scoreboard bench for piso_serializer: accepted words are expanded into
// their expected per-cycle beats by a reference model; a monitor compares
// every cycle of DUT output against the queue.
module tb_piso_serializer;

  localparam int HOLD        = 3;
  localparam int WORD_CYCLES = 8 * HOLD;

`ifdef PISO_MSB_FIRST_EN
  localparam bit MSB_FIRST = 1'b1;
`else
  localparam bit MSB_FIRST = 1'b0;
`endif
  localparam int START_SEL = MSB_FIRST ? 7 : 0;

  typedef struct packed {
    logic [2:0] sel;
    logic       bitVal;
    logic       last;
  } expBeat_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       in_ready;
  logic [2:0] select;
  logic       data_out;
  logic       out_valid;
  logic       last_bit;

  expBeat_t expQ[$];
  int checks = 0;
  int errors = 0;

  piso_serializer #(
    .HOLD_CYCLES(HOLD)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .data_in  (data_in),
    .in_ready (in_ready),
    .select   (select),
    .data_out (data_out),
    .out_valid(out_valid),
    .last_bit (last_bit)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  task automatic check(input string name, input int actual, input int required);
    checks++;
    if (actual != required) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d at t=%0t", name, actual, required, $time);
    end
  endtask

  // Reference model: a word becomes 8 bits in transmission order, each held HOLD cycles.
  task automatic pushWord(input logic [7:0] w);
    expBeat_t b;
    for (int k = 0; k < 8; k++) begin
      int idx;
      idx = MSB_FIRST ? (7 - k) : k;
      for (int h = 0; h < HOLD; h++) begin
        b.sel    = 3'(idx);
        b.bitVal = w[idx];
        b.last   = (k == 7) && (h == HOLD - 1);
        expQ.push_back(b);
      end
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [7:0] d, output bit accepted);
    @(negedge clk);
    in_valid = v;
    data_in  = d;
    accepted = v && in_ready && rst_n;
    if (accepted) pushWord(d);
  endtask

  task automatic sendWord(input logic [7:0] d);
    bit acc;
    int n;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 200) begin
      applyStimulus(1'b1, d, acc);
      n++;
    end
    check("sendAccepted", int'(acc), 1);
  endtask

  task automatic idleCycles(input int n);
    bit acc;
    repeat (n) applyStimulus(1'b0, 8'($urandom), acc);
  endtask

  task automatic waitDrain();
    bit acc;
    int n;
    n = 0;
    while (expQ.size() > 0 && n < 500) begin
      applyStimulus(1'b0, 8'($urandom), acc);
      n++;
    end
    check("drainQueue", expQ.size(), 0);
    applyStimulus(1'b0, 8'($urandom), acc);
  endtask

  task automatic checkOutput();
    expBeat_t e;
    if (!rst_n || expQ.size() == 0) begin
      check("idleOutValid", int'(out_valid), 0);
      check("idleInReady", int'(in_ready), 1);
      check("idleSelect", int'(select), START_SEL);
      check("idleDataOut", int'(data_out), 0);
      check("idleLastBit", int'(last_bit), 0);
    end else begin
      e = expQ.pop_front();
      check("shiftOutValid", int'(out_valid), 1);
      check("shiftInReady", int'(in_ready), 0);
      check("shiftSelect", int'(select), int'(e.sel));
      check("shiftDataOut", int'(data_out), int'(e.bitVal));
      check("shiftLastBit", int'(last_bit), int'(e.last));
    end
  endtask

  // Monitor: compare DUT outputs against the scoreboard shortly after each edge.
  always @(posedge clk) begin
    #1;
    checkOutput();
  end

  // Directed scenarios followed by randomized traffic.
  initial begin
    bit acc;
    int cnt;

    $display("[TB] HOLD=%0d MSB_FIRST=%0d", HOLD, MSB_FIRST);
    repeat (2) @(negedge clk);
    // Release reset and offer a word on the very first edge afterwards.
    rst_n    = 1'b1;
    in_valid = 1'b1;
    data_in  = 8'hAA;
    check("readyAtReleaseA", int'(in_ready), 1);
    pushWord(8'hAA);
    waitDrain();

    sendWord(8'hF0);
    waitDrain();

    // Continuous valid: second word accepted exactly one word plus one idle cycle later.
    sendWord(8'h01);
    cnt = 0;
    acc = 1'b0;
    while (!acc && cnt < 500) begin
      applyStimulus(1'b1, 8'h80, acc);
      cnt++;
    end
    check("backToBackPeriod", cnt, WORD_CYCLES + 1);
    waitDrain();

    // Reset during the 4th bit aborts the word.
    sendWord(8'hFF);
    idleCycles(3 * HOLD + 1);
    rst_n = 1'b0;
    expQ.delete();
    #1;
    check("rstOutValid", int'(out_valid), 0);
    check("rstSelect", int'(select), START_SEL);
    check("rstInReady", int'(in_ready), 1);
    check("rstLastBit", int'(last_bit), 0);
    check("rstDataOut", int'(data_out), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b1;
    data_in  = 8'h0F;
    check("readyAtReleaseB", int'(in_ready), 1);
    pushWord(8'h0F);
    waitDrain();

    // Random valid pattern and data; data_in keeps changing while shifting.
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 3) != 0), 8'($urandom), acc);
    end
    waitDrain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
